// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with majority-vote sampling and error flags
// Ports: clk/reset (async, active-low) | rxd serial line (idles high) | rx_done one-clk frame strobe |
//        data_out last data (LSB first on line) | parity_err, frame_err held until next rx_done |
//        busy from start detection to rx_done/abort | tick one-clk oversample strobe
module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 tick
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] PAR     = 3'd3;
    localparam logic [2:0] STOP    = 3'd4;
    localparam logic [2:0] BRKWAIT = 3'd5;

    logic [2:0]           state;
    logic [DW-1:0]        div_cnt;
    logic [SW-1:0]        sc;
    logic [BW-1:0]        bc;
    logic                 sb;
    logic                 s1, s2;
    logic [1:0]           v;
    logic [DATA_BITS-1:0] sh;
    logic                 perr, ferr;
    logic                 maj, mid, last;

    assign tick = div_cnt == DW'(DIV - 1);
    // votes taken at M-1 and M are held in v; the third is the live sample at M+1
    assign maj  = (v[1] & v[0]) | (v[1] & s2) | (v[0] & s2);
    assign mid  = tick && sc == SW'(M + 1);
    assign last = tick && sc == SW'(OVERSAMPLE - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            {s2, s1} <= 2'b11;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            {s2, s1} <= {s1, rxd};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sc         <= '0;
            bc         <= '0;
            sb         <= 1'b0;
            v          <= 2'b11;
            sh         <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            rx_done    <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (tick)
                sc <= last ? '0 : sc + 1'b1;
            if (tick && (sc == SW'(M - 1) || sc == SW'(M)))
                v <= {v[0], s2};
            case (state)
                IDLE: if (tick && !s2) begin
                    state <= START;
                    sc    <= '0;
                    busy  <= 1'b1;
                    bc    <= '0;
                    sb    <= 1'b0;
                    perr  <= 1'b0;
                    ferr  <= 1'b0;
                end
                START: if (mid && maj) begin
                    state <= IDLE;
                    sc    <= '0;
                    busy  <= 1'b0;
                end else if (last) begin
                    state <= DATA;
                    sc    <= '0;
                end
                DATA: begin
                    if (mid) begin
                        sh <= {maj, sh[DATA_BITS-1:1]};
                        bc <= bc + 1'b1;
                    end
                    if (last) begin
                        sc <= '0;
                        if (bc == BW'(DATA_BITS))
                            state <= PARITY != 0 ? PAR : STOP;
                    end
                end
                PAR: begin
                    // odd mode expects odd total ones, so a clean frame xors to 1
                    if (mid)
                        perr <= maj ^ (^sh) ^ (PARITY == 1);
                    if (last) begin
                        state <= STOP;
                        sc    <= '0;
                    end
                end
                STOP: if (mid) begin
                    if (sb == 1'(STOP_BITS - 1)) begin
                        data_out   <= sh;
                        parity_err <= perr;
                        frame_err  <= ferr | ~maj;
                        rx_done    <= 1'b1;
                        busy       <= 1'b0;
                        state      <= maj ? IDLE : BRKWAIT;
                        sc         <= '0;
                    end else
                        ferr <= ~maj;
                end else if (last) begin
                    sb <= 1'b1;
                    sc <= '0;
                end
                BRKWAIT: if (tick && s2) begin
                    state <= IDLE;
                    sc    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed scoreboard bench for uart_rx_param (8N1 default and 7E1 instances)
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int DIV = 27;
    localparam int BIT = DIV * 16;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic       done_a, pe_a, fe_a, busy_a, tick_a;
    logic [7:0] data_a;
    logic       done_b, pe_b, fe_b, busy_b, tick_b;
    logic [6:0] data_b;

    exp_t q_a[$], q_b[$];
    time  t_a[$];
    int   vectors = 0, miscompares = 0;
    int   cnt_a = 0, cnt_b = 0, exp_a = 0, exp_b = 0;

    always #10 clk = ~clk;

    uart_rx_param dut_a (
        .clk(clk), .reset(reset), .rxd(rxd_a), .rx_done(done_a), .data_out(data_a),
        .parity_err(pe_a), .frame_err(fe_a), .busy(busy_a), .tick(tick_a)
    );

    uart_rx_param #(.PARITY(2), .DATA_BITS(7)) dut_b (
        .clk(clk), .reset(reset), .rxd(rxd_b), .rx_done(done_b), .data_out(data_b),
        .parity_err(pe_b), .frame_err(fe_b), .busy(busy_b), .tick(tick_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic line(input bit b, input logic val, input int n);
        if (b) rxd_b = val;
        else rxd_a = val;
        repeat (n) @(posedge clk);
    endtask

    task automatic send(input bit b, input logic [8:0] d, input int nb, input int pm,
                        input logic pbad, input logic stop);
        logic x;
        exp_t e;
        x = 1'b0;
        for (int i = 0; i < nb; i++) x ^= d[i];
        e.d  = d & 9'((1 << nb) - 1);
        e.pe = pbad;
        e.fe = ~stop;
        if (b) begin q_b.push_back(e); exp_b++; end
        else begin q_a.push_back(e); exp_a++; end
        line(b, 1'b0, BIT);
        for (int i = 0; i < nb; i++) line(b, d[i], BIT);
        if (pm != 0) line(b, (pm == 2 ? x : ~x) ^ pbad, BIT);
        line(b, stop, BIT);
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (done_a) begin
            cnt_a++;
            t_a.push_back($time);
            chk("a_expected_frame", 32'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("a_data", data_a, e.d);
                chk("a_parity_err", pe_a, e.pe);
                chk("a_frame_err", fe_a, e.fe);
                chk("a_busy_at_done", busy_a, 0);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (done_b) begin
            cnt_b++;
            chk("b_expected_frame", 32'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("b_data", data_b, e.d);
                chk("b_parity_err", pe_b, e.pe);
                chk("b_frame_err", fe_b, e.fe);
            end
        end
    end

    initial begin
        time gap;
        int  k;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_done", done_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_perr", pe_a, 0);
        chk("rst_ferr", fe_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_tick", tick_a, 0);
        @(posedge clk);
        reset = 1'b1;
        line(0, 1'b1, BIT);

        send(0, 9'hA5, 8, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_queue_drained", q_a.size(), 0);
        chk("t1_busy_idle", busy_a, 0);

        k = t_a.size();
        send(0, 9'hA5, 8, 0, 1'b0, 1'b1);
        send(0, 9'h5A, 8, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2_queue_drained", q_a.size(), 0);
        chk("t2_two_done", t_a.size() - k, 2);
        if (t_a.size() - k == 2) begin
            gap = t_a[k + 1] - t_a[k];
            chk("t2_b2b_gap", 32'(gap >= 86400 - 540 && gap <= 86400 + 540), 1);
        end

        line(1, 1'b1, BIT);
        send(1, 9'h41, 7, 2, 1'b1, 1'b1);
        send(1, 9'h41, 7, 2, 1'b0, 1'b1);
        line(1, 1'b1, BIT);
        @(negedge clk);
        chk("t3_queue_drained", q_b.size(), 0);
        chk("t3_perr_cleared", pe_b, 0);

        line(0, 1'b0, 60);
        @(negedge clk);
        chk("t4_busy_on_glitch", busy_a, 1);
        line(0, 1'b0, 3 * DIV - 61);
        line(0, 1'b1, BIT);
        @(negedge clk);
        chk("t4_busy_dropped", busy_a, 0);
        chk("t4_data_kept", data_a, 8'h5A);
        chk("t4_no_done", cnt_a, exp_a);

        send(0, 9'h000, 8, 0, 1'b0, 1'b0);
        line(0, 1'b0, BIT);
        @(negedge clk);
        chk("t5_busy_in_break", busy_a, 0);
        line(0, 1'b0, BIT);
        chk("t5_single_done", cnt_a, exp_a);
        line(0, 1'b1, BIT);
        send(0, 9'h03C, 8, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t5_queue_drained", q_a.size(), 0);
        chk("t5_ferr_cleared", fe_a, 0);

        line(0, 1'b0, BIT);
        line(0, 1'b1, 3 * BIT);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_rst_done", done_a, 0);
        chk("t6_rst_data", data_a, 0);
        chk("t6_rst_busy", busy_a, 0);
        chk("t6_rst_tick", tick_a, 0);
        chk("t6_rst_flags", {pe_a, fe_a}, 0);
        @(posedge clk);
        reset = 1'b1;
        line(0, 1'b1, BIT);
        send(0, 9'h081, 8, 0, 1'b0, 1'b1);
        line(0, 1'b1, BIT);
        @(negedge clk);
        chk("t6_queue_drained", q_a.size(), 0);
        chk("final_done_a", cnt_a, exp_a);
        chk("final_done_b", cnt_b, exp_b);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
